// File: rtl/count_seq_pkg.sv
// Shared types for the gated event-count sequencer.
// Latency: n/a (types only).
// Backpressure: n/a.
package count_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_GATE  = 2'd2,
        ST_LATCH = 2'd3
    } state_t;

endpackage

// File: rtl/count_seq_ctrl_event_counter.sv
// Saturating event counter; clr zeroes value and the saturation flag.
// Latency: value updates on the edge after en/clr.
// Backpressure: none; holds at all-ones and flags sat on overflow attempts.
module event_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    output logic [WIDTH-1:0] value,
    output logic             sat
);

    localparam logic [WIDTH-1:0] CNT_MAX = {WIDTH{1'b1}};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value <= '0;
            sat   <= 1'b0;
        end else if (clr) begin
            value <= '0;
            sat   <= 1'b0;
        end else if (en) begin
            if (value == CNT_MAX) begin
                sat <= 1'b1;
            end else begin
                value <= value + WIDTH'(1);
            end
        end
    end

endmodule

// File: rtl/count_seq_ctrl.sv
// Counts qualified events over a GATE_CYCLES window, single-shot or back-to-back.
// Latency: result_valid_o rises GATE_CYCLES+2 edges after start_i is sampled.
// Backpressure: none; an unacknowledged result is overwritten and overrun_o set.
module count_seq_ctrl
    import count_seq_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int GATE_CYCLES = 256
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic             abort_i,
    input  logic             mode_i,
    input  logic             event_i,
    input  logic             result_ready_i,
    output logic [WIDTH-1:0] result_o,
    output logic             result_valid_o,
    output logic             sat_o,
    output logic             overrun_o,
    output logic             busy_o
);

    localparam int              TW         = $clog2(GATE_CYCLES);
    localparam logic [TW-1:0]   TIMER_LOAD = TW'(GATE_CYCLES - 1);

    state_t           state;
    state_t           state_nxt;
    logic [TW-1:0]    timer;
    logic [WIDTH-1:0] cnt_value;
    logic             cnt_sat;
    logic             cnt_clr;
    logic             cnt_en;
    logic             latch_fire;
    logic             arm;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Abort wins over every forward transition, including LATCH.
    always_comb begin
        state_nxt  = state;
        cnt_clr    = 1'b0;
        cnt_en     = 1'b0;
        latch_fire = 1'b0;
        arm        = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start_i && !abort_i) begin
                    state_nxt = ST_CLEAR;
                    arm       = 1'b1;
                end
            end
            ST_CLEAR: begin
                cnt_clr   = 1'b1;
                state_nxt = abort_i ? ST_IDLE : ST_GATE;
            end
            ST_GATE: begin
                cnt_en = event_i && !abort_i;
                if (abort_i) begin
                    state_nxt = ST_IDLE;
                end else if (timer == '0) begin
                    state_nxt = ST_LATCH;
                end
            end
            ST_LATCH: begin
                if (abort_i) begin
                    state_nxt = ST_IDLE;
                end else begin
                    latch_fire = 1'b1;
                    state_nxt  = mode_i ? ST_CLEAR : ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign busy_o = (state != ST_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer <= '0;
        end else if (state == ST_CLEAR) begin
            timer <= TIMER_LOAD;
        end else if (state == ST_GATE && timer != '0) begin
            timer <= timer - TW'(1);
        end
    end

    event_counter #(
        .WIDTH (WIDTH)
    ) u_event_counter (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (cnt_clr),
        .en    (cnt_en),
        .value (cnt_value),
        .sat   (cnt_sat)
    );

    // A fresh latch always leaves valid high, even if the consumer acks on that edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_o       <= '0;
            sat_o          <= 1'b0;
            result_valid_o <= 1'b0;
            overrun_o      <= 1'b0;
        end else begin
            if (latch_fire) begin
                result_o       <= cnt_value;
                sat_o          <= cnt_sat;
                result_valid_o <= 1'b1;
                if (result_valid_o && !result_ready_i) begin
                    overrun_o <= 1'b1;
                end
            end else if (result_valid_o && result_ready_i) begin
                result_valid_o <= 1'b0;
            end
            if (arm) begin
                overrun_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_count_seq_ctrl.sv
// Bench for count_seq_ctrl: directed scenarios plus random traffic vs a window-level model.
// Latency: n/a.
// Backpressure: n/a.
module tb_count_seq_ctrl;

    localparam int G = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start_i = 1'b0;
    logic       abort_i = 1'b0;
    logic       mode_i = 1'b0;
    logic       event_i = 1'b0;
    logic       result_ready_i = 1'b0;
    logic [7:0] res8;
    logic [3:0] res4;
    logic       vld8, sat8, ovr8, busy8;
    logic       vld4, sat4, ovr4, busy4;

    always #5 clk = ~clk;

    count_seq_ctrl #(.WIDTH(8), .GATE_CYCLES(G)) dut8 (
        .clk(clk), .rst_n(rst_n), .start_i(start_i), .abort_i(abort_i),
        .mode_i(mode_i), .event_i(event_i), .result_ready_i(result_ready_i),
        .result_o(res8), .result_valid_o(vld8), .sat_o(sat8),
        .overrun_o(ovr8), .busy_o(busy8)
    );

    count_seq_ctrl #(.WIDTH(4), .GATE_CYCLES(G)) dut4 (
        .clk(clk), .rst_n(rst_n), .start_i(start_i), .abort_i(abort_i),
        .mode_i(mode_i), .event_i(event_i), .result_ready_i(result_ready_i),
        .result_o(res4), .result_valid_o(vld4), .sat_o(sat4),
        .overrun_o(ovr4), .busy_o(busy4)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    // Model: an active window is a position 0 (clear), 1..G (sampled), G+1 (latch).
    bit m_active;
    int m_pos;
    int m_hits;
    int m_lhits;
    bit m_vld;
    bit m_ovr;

    task automatic model_reset();
        m_active = 0; m_pos = 0; m_hits = 0; m_lhits = 0; m_vld = 0; m_ovr = 0;
    endtask

    task automatic model_edge();
        bit ack;
        bit latch;
        ack   = m_vld && result_ready_i;
        latch = 0;
        if (!m_active) begin
            if (start_i && !abort_i) begin
                m_active = 1; m_pos = 0; m_ovr = 0;
            end
        end else if (abort_i) begin
            m_active = 0;
        end else if (m_pos == 0) begin
            m_hits = 0; m_pos = 1;
        end else if (m_pos <= G) begin
            if (event_i) m_hits++;
            m_pos++;
        end else begin
            latch = 1;
            if (mode_i) m_pos = 0;
            else m_active = 0;
        end
        if (latch) begin
            if (m_vld && !result_ready_i) m_ovr = 1;
            m_lhits = m_hits;
            m_vld   = 1;
        end else if (ack) begin
            m_vld = 0;
        end
    endtask

    task automatic compare_all();
        chk("res8",  res8,  (m_lhits > 255) ? 255 : m_lhits);
        chk("sat8",  sat8,  (m_lhits > 255) ? 1 : 0);
        chk("vld8",  vld8,  m_vld);
        chk("ovr8",  ovr8,  m_ovr);
        chk("busy8", busy8, m_active);
        chk("res4",  res4,  (m_lhits > 15) ? 15 : m_lhits);
        chk("sat4",  sat4,  (m_lhits > 15) ? 1 : 0);
        chk("vld4",  vld4,  m_vld);
        chk("ovr4",  ovr4,  m_ovr);
        chk("busy4", busy4, m_active);
    endtask

    task automatic step(input bit s, input bit a, input bit m, input bit e, input bit r);
        start_i = s; abort_i = a; mode_i = m; event_i = e; result_ready_i = r;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare_all();
    endtask

    initial begin
        int edges;
        bit rose;
        model_reset();
        @(negedge clk);
        compare_all();
        rst_n = 1'b1;

        // Held event, single window: latency, full count, 4-bit saturation.
        step(1, 0, 0, 1, 0);
        edges = 0;
        for (int i = 0; i < 40; i++) begin
            step(0, 0, 0, 1, 0);
            edges++;
            if (vld8) break;
        end
        chk("latency", edges, G + 2);
        chk("res_full", res8, 16);
        chk("res_w4", res4, 15);
        chk("sat_w4", sat4, 1);
        step(0, 0, 0, 1, 0);
        chk("busy_after", busy8, 0);
        step(0, 0, 0, 0, 1);
        chk("ack_clears", vld8, 0);

        // Alternating events give half the window.
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < 20; i++) step(0, 0, 0, bit'(i % 2), 0);
        chk("toggle_res", res8, 8);
        chk("toggle_sat", sat8, 0);
        step(0, 0, 0, 0, 1);

        // Abort on the 5th sampled cycle.
        step(1, 0, 0, 1, 0);
        step(0, 0, 0, 1, 0);
        repeat (4) step(0, 0, 0, 1, 0);
        step(0, 1, 0, 1, 0);
        chk("abort_busy", busy8, 0);
        rose = 0;
        repeat (30) begin
            step(0, 0, 0, 1, 0);
            if (vld8) rose = 1;
        end
        chk("abort_novalid", rose, 0);

        // Continuous mode, no acknowledge across two windows.
        step(1, 0, 1, 1, 0);
        repeat (2 * (G + 2)) step(0, 0, 1, 1, 0);
        chk("overrun", ovr8, 1);
        chk("overrun_vld", vld8, 1);
        chk("overrun_res", res8, 16);
        step(0, 0, 1, 1, 1);
        chk("overrun_ack", vld8, 0);
        step(0, 1, 0, 1, 0);

        // Asynchronous reset in the middle of a window.
        step(1, 0, 0, 1, 0);
        repeat (8) step(0, 0, 0, 1, 0);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        chk("rst_res",  res8, 0);
        chk("rst_vld",  vld8, 0);
        chk("rst_sat",  sat8, 0);
        chk("rst_ovr",  ovr8, 0);
        chk("rst_busy", busy8, 0);
        @(negedge clk);
        rst_n = 1'b1;
        compare_all();
        step(1, 0, 0, 1, 0);
        repeat (G + 2) step(0, 0, 0, 1, 0);
        chk("post_rst_res", res8, 16);
        chk("post_rst_vld", vld8, 1);

        // Random traffic.
        for (int i = 0; i < 1500; i++) begin
            step(bit'($urandom_range(0, 7) == 0), bit'($urandom_range(0, 47) == 0),
                 bit'($urandom_range(0, 3) == 0), bit'($urandom_range(0, 1)),
                 bit'($urandom_range(0, 2) == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/count_seq_ctrl.md
COUNT_SEQ_CTRL -- requirements
Module: count_seq_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 8, which sets the event count and result width in bits.
REQ-002 SHALL have parameter GATE_CYCLES, default 256, which sets the measurement window length in clock cycles (legal range ≥2).
REQ-003 SHALL have port clk, input, width 1: single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_n, input, width 1: reset, asynchronous and active-low.
REQ-005 SHALL have port start_i, input, width 1: request a measurement; sampled in IDLE only.
REQ-006 SHALL have port abort_i, input, width 1: cancel an active measurement.
REQ-007 SHALL have port mode_i, input, width 1: 0 = single window, 1 = continuous back-to-back windows.
REQ-008 SHALL have port event_i, input, width 1: qualified event (e.g. AND of all input pads); counted once per cycle while high.
REQ-009 SHALL have port result_ready_i, input, width 1: consumer acknowledge of the result.
REQ-010 SHALL have port result_o, output, width WIDTH: count of the last completed window.
REQ-011 SHALL have port result_valid_o, output, width 1: result_o holds an unacknowledged result.
REQ-012 SHALL have port sat_o, output, width 1: the window belonging to result_o saturated.
REQ-013 SHALL have port overrun_o, output, width 1: sticky flag; an unacknowledged result was overwritten.
REQ-014 SHALL have port busy_o, output, width 1: high in every state except IDLE.

Function
REQ-015 SHALL implement states IDLE, CLEAR, GATE, LATCH.
REQ-016 SHALL move IDLE->CLEAR on start_i=1 and abort_i=0, and clear overrun_o on that transition.
REQ-017 SHALL, in CLEAR (one cycle), zero the counter and load the window timer with GATE_CYCLES-1, then go to GATE.
REQ-018 SHALL, in GATE, increment the counter on each cycle with event_i=1 and decrement the timer each cycle; on timer==0, after counting that cycle, go to LATCH (exactly GATE_CYCLES sampled cycles).
REQ-019 SHALL hold the counter at 2^WIDTH-1 instead of wrapping, and set the window's saturation flag when an increment is attempted at the maximum.
REQ-020 SHALL, in LATCH, load result_o and sat_o, set result_valid_o=1, then go to IDLE if mode_i=0 or to CLEAR if mode_i=1.
REQ-021 SHALL raise result_valid_o exactly GATE_CYCLES+2 rising edges after the edge that samples start_i; in continuous mode, result period is GATE_CYCLES+2 cycles.
REQ-022 SHALL clear result_valid_o on the edge where result_valid_o=1 and result_ready_i=1; result_o remains stable while valid.
REQ-023 SHALL, if LATCH occurs while result_valid_o=1 and result_ready_i=0, overwrite result_o/sat_o, keep valid=1 and set overrun_o; an acknowledge on the same edge does not set overrun_o, and valid stays 1.
REQ-024 SHALL treat abort_i=1 in CLEAR/GATE/LATCH as going to IDLE next edge with no new result and no change to result_o/result_valid_o; abort has priority over start and over LATCH.
REQ-025 SHALL ignore start_i outside IDLE.
REQ-026 SHALL size the timer to $clog2(GATE_CYCLES) bits.

Reset
REQ-027 SHALL on rst_n=0 immediately force state IDLE, counter 0, timer 0, result_o 0, result_valid_o 0, sat_o 0, overrun_o 0, busy_o 0, including mid-window.
REQ-028 SHALL resume in IDLE after reset release, requiring a fresh start_i.

Structure
REQ-029 SHALL place the state enum typedef in package count_seq_pkg.
REQ-030 SHALL instantiate sub-module event_counter (saturating WIDTH-bit counter with clr, en, value and sat outputs); FSM, timer and result register remain in count_seq_ctrl.

Verification (WIDTH=8, GATE_CYCLES=16 unless stated)
REQ-031 SHALL cover: event_i held 1, single mode, start pulse -> result_o=16, sat_o=0, valid 18 edges after start, busy_o low after LATCH.
REQ-032 SHALL cover: event_i toggling 1,0,1,0 -> result_o=8.
REQ-033 SHALL cover: WIDTH=4, event_i held 1 -> result_o=15, sat_o=1.
REQ-034 SHALL cover: abort_i at 5th GATE cycle -> IDLE next edge, busy_o=0, result_valid_o never rises.
REQ-035 SHALL cover: mode_i=1, result_ready_i=0 for two windows -> second result overwrites, overrun_o=1; then ready=1 -> valid=0 next edge.
REQ-036 SHALL cover: rst_n low mid-GATE -> all outputs 0 without waiting for a clock edge; start after release gives result_o=16.
